fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 10 +
 rtl/fetch_unit_sync_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths and types for the fetch path.
package C;
   localparam int XLEN       = 32;
   localparam int MEM_AWIDTH = 20;

   typedef struct packed {
      logic [MEM_AWIDTH-1:0] addr;
      logic [XLEN-1:0]       data;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Generic synchronous FIFO with flush; flush dominates push and pop.
// Read data is the head entry, combinationally visible while not empty.
module sync_fifo
   import C::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !flush;
   assign do_pop  = pop && !flush && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is don't-care until written, so it carries no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   a_no_overflow:  assert property (@(posedge clk) disable iff (!rstn) !(push && full && !flush));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rstn) !(pop && empty && !flush));
endmodule

// File: rtl/fetch_unit.sv
// Sequential word fetch from sram1rw into a credit-checked output buffer with redirect.
// Request in cycle N appears on instr_* in N+2; issue stalls when buffer plus in-flight reaches depth.
module fetch_unit
   import C::*;
#(
   parameter int                  ADDR_WIDTH = MEM_AWIDTH,
   parameter int                  DATA_WIDTH = XLEN,
   parameter int                  FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic                  clk,
   input  logic                  rstn,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_req_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic [DATA_WIDTH-1:0] instr_data_o,
   output logic [ADDR_WIDTH-1:0] instr_addr_o,
   input  logic                  redirect_valid_i,
   input  logic [ADDR_WIDTH-1:0] redirect_addr_i
);
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  inflight_q, inflight_d;
   logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
   logic                  redir_q, redir_d;

   entry_t        push_entry, head_entry;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty, fifo_full;
   logic          credit_ok, fifo_push, fifo_pop;

   // Credit counts buffered words plus the one still in the SRAM pipe.
   assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
   assign mem_req_o = rstn && !redir_q && credit_ok;
   assign mem_addr_o = pc_q;

   assign push_entry = '{addr: inflight_addr_q, data: mem_rdata_i};
   assign fifo_push  = inflight_q && !redirect_valid_i;
   assign fifo_pop   = instr_valid_o && instr_ready_i && !redirect_valid_i;

   always_comb begin
      pc_d            = pc_q;
      inflight_d      = 1'b0;
      inflight_addr_d = inflight_addr_q;
      redir_d         = 1'b0;
      if (redirect_valid_i) begin
         pc_d    = redirect_addr_i;
         redir_d = 1'b1;
      end else if (mem_req_o) begin
         pc_d            = pc_q + ADDR_WIDTH'(1);
         inflight_d      = 1'b1;
         inflight_addr_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q            <= RESET_ADDR;
         inflight_q      <= 1'b0;
         inflight_addr_q <= RESET_ADDR;
         redir_q         <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
         redir_q         <= redir_d;
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .flush (redirect_valid_i),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (push_entry),
      .rdata (head_entry),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign instr_valid_o = !fifo_empty;
   assign instr_data_o  = head_entry.data;
   assign instr_addr_o  = head_entry.addr;

   a_credit: assert property (@(posedge clk) disable iff (!rstn) !(fifo_push && fifo_full));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an sram1rw model and an address/data scoreboard.
module tb_fetch_unit;
   logic        clk;
   logic        rstn;
   logic [19:0] mem_addr_o;
   logic        mem_req_o;
   logic [31:0] mem_rdata_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_data_o;
   logic [19:0] instr_addr_o;
   logic        redirect_valid_i;
   logic [19:0] redirect_addr_i;

   int tests = 0;
   int fails = 0;
   logic [19:0] exp_q[$];

   fetch_unit dut (
      .clk              (clk),
      .rstn             (rstn),
      .mem_addr_o       (mem_addr_o),
      .mem_req_o        (mem_req_o),
      .mem_rdata_i      (mem_rdata_i),
      .instr_valid_o    (instr_valid_o),
      .instr_ready_i    (instr_ready_i),
      .instr_data_o     (instr_data_o),
      .instr_addr_o     (instr_addr_o),
      .redirect_valid_i (redirect_valid_i),
      .redirect_addr_i  (redirect_addr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mdata(input logic [19:0] a);
      return 32'h1000 + {12'h000, a};
   endfunction

   // sram1rw: reads mem_addr_o every cycle, data one cycle later.
   always @(posedge clk) mem_rdata_i <= mdata(mem_addr_o);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_exp(input logic [19:0] start, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(start + 20'(i));
   endtask

   // Scoreboard: every accepted word must be the next expected address with matching data.
   always @(negedge clk) begin
      if (rstn && !redirect_valid_i && instr_valid_o && instr_ready_i) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word_addr", {12'h0, instr_addr_o}, 32'hFFFF_FFFF);
         end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            chk("word_addr", {12'h0, instr_addr_o}, {12'h0, e});
            chk("word_data", instr_data_o, mdata(e));
         end
      end
   end

   initial begin
      int n;
      rstn             = 1'b0;
      instr_ready_i    = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_addr_i  = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("reset_req", {31'h0, mem_req_o}, 32'h0);
      chk("reset_valid", {31'h0, instr_valid_o}, 32'h0);
      chk("reset_addr", {12'h0, mem_addr_o}, 32'h0);

      // Streaming from RESET_ADDR
      tick();
      rstn = 1'b1;
      instr_ready_i = 1'b1;
      load_exp(20'h0, 40);
      @(negedge clk);
      chk("first_req", {31'h0, mem_req_o}, 32'h1);
      chk("first_req_addr", {12'h0, mem_addr_o}, 32'h0);
      n = 0;
      while (!instr_valid_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, 2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stream_valid", {31'h0, instr_valid_o}, 32'h1);
      end

      // Backpressure: buffer fills and issue stops
      tick();
      instr_ready_i = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      chk("stall_req", {31'h0, mem_req_o}, 32'h0);
      chk("stall_valid", {31'h0, instr_valid_o}, 32'h1);
      tick();
      @(negedge clk);
      chk("stall_req_hold", {31'h0, mem_req_o}, 32'h0);
      tick();
      instr_ready_i = 1'b1;
      repeat (8) tick();

      // Redirect while streaming
      redirect_valid_i = 1'b1;
      redirect_addr_i  = 20'h00100;
      load_exp(20'h00100, 16);
      tick();
      redirect_valid_i = 1'b0;
      @(negedge clk);
      chk("redir_gap_req", {31'h0, mem_req_o}, 32'h0);
      chk("redir_gap_addr", {12'h0, mem_addr_o}, 32'h00100);
      chk("redir_flush_valid", {31'h0, instr_valid_o}, 32'h0);
      @(negedge clk);
      chk("redir_resume_req", {31'h0, mem_req_o}, 32'h1);
      repeat (5) tick();

      // Redirect across the address wrap
      redirect_valid_i = 1'b1;
      redirect_addr_i  = 20'hFFFFE;
      load_exp(20'hFFFFE, 8);
      tick();
      redirect_valid_i = 1'b0;
      @(negedge clk);
      chk("wrap_gap_addr", {12'h0, mem_addr_o}, 32'hFFFFE);
      repeat (8) tick();
      instr_ready_i = 1'b0;
      repeat (8) tick();
      @(negedge clk);
      chk("wrap_full_req", {31'h0, mem_req_o}, 32'h0);

      // Redirect on a full stall with a simultaneous pop
      tick();
      instr_ready_i    = 1'b1;
      redirect_valid_i = 1'b1;
      redirect_addr_i  = 20'h00200;
      load_exp(20'h00200, 16);
      tick();
      redirect_valid_i = 1'b0;
      @(negedge clk);
      chk("full_redir_valid", {31'h0, instr_valid_o}, 32'h0);
      chk("full_redir_req", {31'h0, mem_req_o}, 32'h0);
      n = 0;
      while (!instr_valid_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("full_redir_head", {12'h0, instr_addr_o}, 32'h00200);
      repeat (3) tick();

      // Reset while three words are buffered
      instr_ready_i = 1'b0;
      tick();
      tick();
      rstn = 1'b0;
      load_exp(20'h0, 16);
      tick();
      rstn = 1'b1;
      instr_ready_i = 1'b1;
      @(negedge clk);
      chk("rst_mid_valid", {31'h0, instr_valid_o}, 32'h0);
      chk("rst_mid_req", {31'h0, mem_req_o}, 32'h1);
      chk("rst_mid_addr", {12'h0, mem_addr_o}, 32'h0);
      repeat (10) tick();
      @(negedge clk);
      chk("rst_stream_valid", {31'h0, instr_valid_o}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
